// File: rtl/write_back_buffered.sv
// Write-back stage: formats load data at push time, queues results, drives the register-file write port.
// Latency: an entry accepted at edge N is visible on wb_* from cycle N+1; one retire per cycle.
// Backpressure: mem_ready drops when the FIFO is full; only writing heads wait on rf_ready.

// Generic synchronous FIFO with occupancy count; head is shown combinationally.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [WIDTH-1:0]           in_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [WIDTH-1:0]           out_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_WW = $clog2(DEPTH + 1);
    localparam logic [CNT_WW-1:0] FULL = CNT_WW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    assign in_rdy  = !rst && (count < FULL);
    assign out_vld = !rst && (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module write_back_buffered #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [XLEN-1:0]            mem_result,
    input  logic [2:0]                 mem_funct3,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       mem_write_reg,
    input  logic                       mem_select,
    output logic [XLEN-1:0]            wb_data,
    output logic [4:0]                 wb_rd,
    output logic                       wb_write_reg,
    input  logic                       rf_ready,
    output logic                       load_fault,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [CNT_W-1:0]           retired_count
);
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
        logic            fault;
    } wb_entry_t;

    wb_entry_t        in_entry;
    wb_entry_t        head;
    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_data;
    logic             misaligned;
    logic             illegal;
    logic             fault;
    logic             head_vld;
    logic             head_rdy;

    assign off     = mem_result[OFF_W-1:0];
    assign shifted = mem_data >> {off, 3'b000};

    always_comb begin
        load_data = '0;
        case (mem_funct3)
            3'b000:  load_data = XLEN'(signed'(shifted[7:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b001:  load_data = XLEN'(signed'(shifted[15:0]));
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b010:  load_data = XLEN'(signed'(shifted[31:0]));
            3'b110:  load_data = XLEN'(shifted[31:0]);
            3'b011:  load_data = mem_data;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (mem_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            2'b11:   misaligned = (off != '0);
            default: misaligned = 1'b0;
        endcase
    end

    // LWU and LD only exist on RV64.
    assign illegal = (mem_funct3 == 3'b111) ||
                     ((XLEN == 32) && ((mem_funct3 == 3'b110) || (mem_funct3 == 3'b011)));
    assign fault   = mem_select && (misaligned || illegal);

    always_comb begin
        in_entry       = '0;
        in_entry.data  = mem_select ? (fault ? '0 : load_data) : mem_result;
        in_entry.rd    = mem_rd;
        in_entry.fault = fault;
        in_entry.we    = mem_write_reg && (mem_rd != 5'd0) && !fault;
    end

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (mem_valid),
        .in_rdy  (mem_ready),
        .in_dat  (in_entry),
        .out_vld (head_vld),
        .out_rdy (head_rdy),
        .out_dat (head),
        .count   (fifo_count)
    );

    // Entries that write nothing never need the register-file port.
    assign head_rdy = rf_ready || !head.we;

    always_comb begin
        wb_data      = '0;
        wb_rd        = '0;
        wb_write_reg = 1'b0;
        load_fault   = 1'b0;
        if (head_vld) begin
            wb_data      = head.data;
            wb_rd        = head.rd;
            wb_write_reg = head.we;
            load_fault   = head.fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count <= '0;
        end else if (head_vld && head_rdy) begin
            retired_count <= retired_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_write_back_buffered.sv
// Directed bench for write_back_buffered at XLEN=32, DEPTH=2, CNT_W=32.
module tb_write_back_buffered;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_result;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_write_reg;
    logic        mem_select;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_write_reg;
    logic        rf_ready;
    logic        load_fault;
    logic [1:0]  fifo_count;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

    write_back_buffered #(.XLEN(32), .DEPTH(2), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_result    (mem_result),
        .mem_funct3    (mem_funct3),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_write_reg (mem_write_reg),
        .mem_select    (mem_select),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_write_reg  (wb_write_reg),
        .rf_ready      (rf_ready),
        .load_fault    (load_fault),
        .fifo_count    (fifo_count),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] res, input logic [2:0] f3, input logic [4:0] rd,
                          input logic wr, input logic sel);
        mem_result    = res;
        mem_funct3    = f3;
        mem_rd        = rd;
        mem_write_reg = wr;
        mem_select    = sel;
    endtask

    task automatic push(input logic [31:0] res, input logic [2:0] f3, input logic [4:0] rd,
                        input logic wr, input logic sel);
        set_in(res, f3, rd, wr, sel);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ld_off [5] = '{32'd0, 32'd3, 32'd2, 32'd0, 32'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0,
                                32'h0000_7F81, 32'h80F0_7F81};

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0;
        mem_data = 32'h80F0_7F81;
        rf_ready = 1'b1;
        set_in(32'h0, 3'b000, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_we", wb_write_reg, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_fault", load_fault, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_retired", retired_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", mem_ready, 1);

        // ALU result
        push(32'h1234, 3'b000, 5'd5, 1'b1, 1'b0);
        chk("alu_we", wb_write_reg, 1);
        chk("alu_rd", wb_rd, 5);
        chk("alu_data", wb_data, 32'h0000_1234);
        chk("alu_count", fifo_count, 1);
        tick();
        chk("alu_retired", retired_count, 1);
        chk("alu_drained", fifo_count, 0);

        // load formatting
        for (int i = 0; i < 5; i++) begin
            push(32'h1000 + ld_off[i], ld_f3[i], 5'd7, 1'b1, 1'b1);
            chk($sformatf("load%0d_data", i), wb_data, ld_exp[i]);
            chk($sformatf("load%0d_fault", i), load_fault, 0);
            tick();
        end
        chk("load_retired", retired_count, 6);

        // faults retire without rf_ready
        rf_ready = 1'b0;
        push(32'h1002, 3'b010, 5'd9, 1'b1, 1'b1);
        chk("mis_fault", load_fault, 1);
        chk("mis_we", wb_write_reg, 0);
        chk("mis_data", wb_data, 0);
        tick();
        chk("mis_retired", retired_count, 7);
        chk("mis_count", fifo_count, 0);
        push(32'h1000, 3'b111, 5'd9, 1'b1, 1'b1);
        chk("ill_fault", load_fault, 1);
        chk("ill_we", wb_write_reg, 0);
        tick();
        chk("ill_retired", retired_count, 8);
        push(32'h1001, 3'b001, 5'd9, 1'b1, 1'b1);
        chk("mis_lh_fault", load_fault, 1);
        tick();
        chk("mis_lh_retired", retired_count, 9);

        // backpressure with three offered pushes
        push(32'hA1, 3'b000, 5'd1, 1'b1, 1'b0);
        push(32'hB2, 3'b000, 5'd2, 1'b1, 1'b0);
        chk("bp_count2", fifo_count, 2);
        chk("bp_ready0", mem_ready, 0);
        push(32'hC3, 3'b000, 5'd3, 1'b1, 1'b0);
        chk("bp_still2", fifo_count, 2);
        chk("bp_head_rd", wb_rd, 1);
        chk("bp_head_data", wb_data, 32'hA1);
        chk("bp_head_we", wb_write_reg, 1);
        tick();
        chk("bp_hold_data", wb_data, 32'hA1);
        rf_ready = 1'b1;
        tick();
        chk("bp_drain1_rd", wb_rd, 2);
        chk("bp_drain1_cnt", fifo_count, 1);
        tick();
        chk("bp_drain2_cnt", fifo_count, 0);
        chk("bp_retired", retired_count, 11);

        // full FIFO: push and pop on the same edge
        rf_ready = 1'b0;
        push(32'hD1, 3'b000, 5'd4, 1'b1, 1'b0);
        push(32'hD2, 3'b000, 5'd6, 1'b1, 1'b0);
        rf_ready = 1'b1;
        set_in(32'hD3, 3'b000, 5'd8, 1'b1, 1'b0);
        mem_valid = 1'b1;
        #1;
        chk("full_ready0", mem_ready, 0);
        tick();
        chk("full_pop_cnt", fifo_count, 1);
        chk("full_pop_head", wb_rd, 6);
        chk("full_ready1", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        chk("pushpop_cnt", fifo_count, 1);
        chk("pushpop_head", wb_data, 32'hD3);
        tick();
        chk("pushpop_drain", fifo_count, 0);
        chk("pushpop_retired", retired_count, 14);

        // write to x0 never waits on the port
        rf_ready = 1'b0;
        push(32'h55, 3'b000, 5'd0, 1'b1, 1'b0);
        chk("x0_we", wb_write_reg, 0);
        chk("x0_data", wb_data, 32'h55);
        tick();
        chk("x0_count", fifo_count, 0);
        chk("x0_retired", retired_count, 15);

        // reset with two queued writes
        push(32'hE1, 3'b000, 5'd10, 1'b1, 1'b0);
        push(32'hE2, 3'b000, 5'd11, 1'b1, 1'b0);
        chk("mid_count2", fifo_count, 2);
        rf_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", wb_write_reg, 0);
        chk("mid_rst_data", wb_data, 0);
        chk("mid_rst_rd", wb_rd, 0);
        chk("mid_rst_ready", mem_ready, 0);
        tick();
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_retired", retired_count, 0);
        rst = 1'b0;
        #1;
        chk("mid_post_we", wb_write_reg, 0);
        chk("mid_post_ready", mem_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
